// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin arbiter sharing one LedBank between NREQ
// requesters. Each requester offers a 12-bit instruction {opcode, imm} on a
// valid/ready handshake. The arbiter issues at most one instruction per cycle
// to LedBank and can insert GAP idle cycles after each issue.
//
// Optional feature: LED_BANK_ARB_FILTER_EN. When defined, instructions with an
// unknown opcode are still accepted but not forwarded, and drop_count counts them.
//
// Handshake: a transfer from requester i happens in any cycle where
// req_valid[i] & req_ready[i] is high. req_ready is combinational and one-hot
// or zero. The requester may change or withdraw its offer freely while not
// ready, because the arbiter keeps no copy of unaccepted data.

`ifndef LedBank_NOP
`define LedBank_NOP 4'h0
`endif
`ifndef LedBank_LDI
`define LedBank_LDI 4'h1
`endif
`ifndef LedBank_LD0
`define LedBank_LD0 4'h2
`endif
`ifndef LedBank_LD7
`define LedBank_LD7 4'h9
`endif

module led_bank_arbiter #(
    parameter int IDW = 2,
    parameter int GAP = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [(1<<IDW)*12-1:0] req_inst,
    input  logic [(1<<IDW)-1:0]    req_valid,
    output logic [(1<<IDW)-1:0]    req_ready,
    output logic [11:0]            inst,
    output logic                   inst_en,
    output logic [IDW-1:0]         grant_id
`ifdef LED_BANK_ARB_FILTER_EN
    ,
    output logic [7:0]             drop_count
`endif
);

    localparam int NREQ = 1 << IDW;

    typedef enum logic {
        ARB  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [7:0]     cnt;

    logic           found;
    logic [IDW-1:0] win;
    logic [11:0]    win_inst;
    logic           forward;

    // Pick the first valid requester scanning from the round-robin pointer.
    always_comb begin
        logic [IDW-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + IDW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_inst = req_inst[12*win +: 12];

    // Decide whether the winner's instruction is passed on to LedBank.
    always_comb begin
`ifdef LED_BANK_ARB_FILTER_EN
        forward = (win_inst[11:8] == `LedBank_NOP) ||
                  (win_inst[11:8] == `LedBank_LDI) ||
                  ((win_inst[11:8] >= `LedBank_LD0) && (win_inst[11:8] <= `LedBank_LD7));
`else
        forward = 1'b1;
`endif
    end

    // One-hot accept for the winner, only while arbitrating and out of reset.
    always_comb begin
        req_ready = '0;
        if (!reset && state == ARB && found)
            req_ready[win] = 1'b1;
    end

    // Arbitration FSM with registered LedBank outputs and gap counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ARB;
            ptr      <= '0;
            cnt      <= 8'd0;
            inst     <= {`LedBank_NOP, 8'h00};
            inst_en  <= 1'b0;
            grant_id <= '0;
`ifdef LED_BANK_ARB_FILTER_EN
            drop_count <= 8'd0;
`endif
        end else begin
            inst    <= {`LedBank_NOP, 8'h00};
            inst_en <= 1'b0;
            case (state)
                ARB: begin
                    if (found) begin
                        ptr <= win + IDW'(1);
                        if (forward) begin
                            inst     <= win_inst;
                            inst_en  <= 1'b1;
                            grant_id <= win;
                            if (GAP > 0) begin
                                state <= WAIT;
                                cnt   <= 8'(GAP);
                            end
                        end
`ifdef LED_BANK_ARB_FILTER_EN
                        else if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
`endif
                    end
                end
                WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1)
                        state <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter: one DUT with GAP=0 and one with GAP=3
// share the requester inputs; each scenario task checks the relevant DUT.
module tb_led_bank_arbiter;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;

    logic        clock;
    logic        reset;
    logic [47:0] req_inst;
    logic [3:0]  req_valid;

    logic [3:0]  ready0, ready3;
    logic [11:0] inst0, inst3;
    logic        en0, en3;
    logic [1:0]  gid0, gid3;
`ifdef LED_BANK_ARB_FILTER_EN
    logic [7:0]  drop0, drop3;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    led_bank_arbiter #(.IDW(2), .GAP(0)) u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .req_inst  (req_inst),
        .req_valid (req_valid),
        .req_ready (ready0),
        .inst      (inst0),
        .inst_en   (en0),
        .grant_id  (gid0)
`ifdef LED_BANK_ARB_FILTER_EN
        ,
        .drop_count(drop0)
`endif
    );

    led_bank_arbiter #(.IDW(2), .GAP(3)) u_dut3 (
        .clock     (clock),
        .reset     (reset),
        .req_inst  (req_inst),
        .req_valid (req_valid),
        .req_ready (ready3),
        .inst      (inst3),
        .inst_en   (en3),
        .grant_id  (gid3)
`ifdef LED_BANK_ARB_FILTER_EN
        ,
        .drop_count(drop3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [3:0] op, input logic [7:0] imm);
        req_inst[12*i +: 12] = {op, imm};
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        #1;
        vec_cnt++;
        if (ready0 !== 4'b0000 || ready3 !== 4'b0000) begin
            $display("FAIL reset_ready: got %b/%b expected 0000", ready0, ready3);
            err_cnt++;
        end
        tick();
        tick();
        vec_cnt++;
        if (gid0 !== 2'd0 || gid3 !== 2'd0 || en3 !== 1'b0) begin
            $display("FAIL reset_regs: gid %0d/%0d en3 %b expected 0/0/0", gid0, gid3, en3);
            err_cnt++;
        end
        reset = 1'b0;
        req_valid = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            vec_cnt++;
            if (en0 !== 1'b0 || inst0 !== {OP_NOP, 8'h00} || ready0 !== 4'b0000) begin
                $display("FAIL reset_idle[%0d]: en=%b inst=%h ready=%b expected 0 000 0000",
                         k, en0, inst0, ready0);
                err_cnt++;
            end
        end
    endtask

    task automatic test_single();
        set_slot(2, OP_LDI, 8'hD7);
        req_valid = 4'b0100;
        #1;
        vec_cnt++;
        if (ready0 !== 4'b0100) begin
            $display("FAIL single_ready0: got %b expected 0100", ready0);
            err_cnt++;
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vec_cnt++;
            if (en0 !== 1'b1 || inst0 !== {OP_LDI, 8'hD7} || gid0 !== 2'd2 || ready0 !== 4'b0100) begin
                $display("FAIL single[%0d]: en=%b inst=%h gid=%0d ready=%b expected 1 1d7 2 0100",
                         k, en0, inst0, gid0, ready0);
                err_cnt++;
            end
        end
        req_valid = 4'b0000;
        tick();
        vec_cnt++;
        if (en0 !== 1'b0 || inst0 !== {OP_NOP, 8'h00} || gid0 !== 2'd2) begin
            $display("FAIL single_idle: en=%b inst=%h gid=%0d expected 0 000 2", en0, inst0, gid0);
            err_cnt++;
        end
    endtask

    task automatic test_rotate();
        logic [1:0] exp_gid [5];
        exp_gid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, OP_LDI, 8'h10 + 8'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            vec_cnt++;
            if (en0 !== 1'b1 || gid0 !== exp_gid[k] || inst0 !== {OP_LDI, 8'h10 + 8'(exp_gid[k])}) begin
                $display("FAIL rotate[%0d]: en=%b gid=%0d inst=%h expected 1 %0d 1%h",
                         k, en0, gid0, inst0, exp_gid[k], 8'h10 + 8'(exp_gid[k]));
                err_cnt++;
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_gap();
        logic       exp_en;
        logic [1:0] exp_gid;
        logic [3:0] exp_rdy;
        do_reset();
        set_slot(1, OP_LDI, 8'h01);
        set_slot(3, OP_LDI, 8'h03);
        req_valid = 4'b1010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_en  = (k % 4 == 1);
            exp_gid = (k == 5) ? 2'd3 : 2'd1;
            exp_rdy = (k % 4 != 0) ? 4'b0000 : ((k == 8) ? 4'b0010 : 4'b1000);
            vec_cnt++;
            if (en3 !== exp_en || ready3 !== exp_rdy || (exp_en && gid3 !== exp_gid)) begin
                $display("FAIL gap[%0d]: en=%b ready=%b gid=%0d expected %b %b %0d",
                         k, en3, ready3, gid3, exp_en, exp_rdy, exp_gid);
                err_cnt++;
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_slot(1, OP_LDI, 8'hA5);
        req_valid = 4'b0010;
        tick();
        vec_cnt++;
        if (en0 !== 1'b1 || inst0 !== {OP_LDI, 8'hA5} || gid0 !== 2'd1) begin
            $display("FAIL mid_issue: en=%b inst=%h gid=%0d expected 1 1a5 1", en0, inst0, gid0);
            err_cnt++;
        end
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (ready0 !== 4'b0000) begin
            $display("FAIL mid_ready: got %b expected 0000", ready0);
            err_cnt++;
        end
        tick();
        reset = 1'b0;
        vec_cnt++;
        if (en0 !== 1'b0 || inst0 !== {OP_NOP, 8'h00} || gid0 !== 2'd0) begin
            $display("FAIL mid_reset: en=%b inst=%h gid=%0d expected 0 000 0", en0, inst0, gid0);
            err_cnt++;
        end
        set_slot(0, OP_LDI, 8'h40);
        set_slot(3, OP_LDI, 8'h43);
        req_valid = 4'b1011;
        tick();
        vec_cnt++;
        if (en0 !== 1'b1 || gid0 !== 2'd0 || inst0 !== {OP_LDI, 8'h40}) begin
            $display("FAIL mid_after: en=%b gid=%0d inst=%h expected 1 0 140", en0, gid0, inst0);
            err_cnt++;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_filter();
        do_reset();
        set_slot(0, 4'hE, 8'hAA);
        req_valid = 4'b0001;
        #1;
        vec_cnt++;
        if (ready0 !== 4'b0001) begin
            $display("FAIL filter_ready: got %b expected 0001", ready0);
            err_cnt++;
        end
        tick();
`ifdef LED_BANK_ARB_FILTER_EN
        vec_cnt++;
        if (en0 !== 1'b0 || drop0 !== 8'd1 || inst0 !== {OP_NOP, 8'h00}) begin
            $display("FAIL filter_drop: en=%b drop=%0d inst=%h expected 0 1 000", en0, drop0, inst0);
            err_cnt++;
        end
        vec_cnt++;
        if (ready3 !== 4'b0001) begin
            $display("FAIL filter_nowait: got %b expected 0001", ready3);
            err_cnt++;
        end
`else
        vec_cnt++;
        if (en0 !== 1'b1 || inst0 !== {4'hE, 8'hAA}) begin
            $display("FAIL filter_fwd: en=%b inst=%h expected 1 eaa", en0, inst0);
            err_cnt++;
        end
        vec_cnt++;
        if (ready3 !== 4'b0000) begin
            $display("FAIL filter_wait: got %b expected 0000", ready3);
            err_cnt++;
        end
`endif
        set_slot(0, OP_LDI, 8'h25);
        tick();
        vec_cnt++;
        if (en0 !== 1'b1 || inst0 !== {OP_LDI, 8'h25} || gid0 !== 2'd0) begin
            $display("FAIL filter_next: en=%b inst=%h gid=%0d expected 1 125 0", en0, inst0, gid0);
            err_cnt++;
        end
`ifdef LED_BANK_ARB_FILTER_EN
        vec_cnt++;
        if (drop0 !== 8'd1) begin
            $display("FAIL filter_count: got %0d expected 1", drop0);
            err_cnt++;
        end
`endif
        req_valid = 4'b0000;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_inst  = '0;
        test_reset();
        test_single();
        test_rotate();
        test_gap();
        test_reset_mid();
        test_filter();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
